// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the 4x4 FFT / inverse FFT path.
package fft_pkg;

    localparam int FFT_N    = 4;
    localparam int FFT_W    = 16;
    localparam int FFT_GROW = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_COL  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } fft_state_e;

endpackage

// File: rtl/ifft4_butterfly.sv
// Combinational 4-point inverse DFT; outputs grow by two bits over the inputs.
module ifft4_butterfly
    import fft_pkg::*;
#(
    parameter int IW = 20
) (
    input  logic signed [IW-1:0] x_re [FFT_N],
    input  logic signed [IW-1:0] x_im [FFT_N],
    output logic signed [IW+1:0] y_re [FFT_N],
    output logic signed [IW+1:0] y_im [FFT_N]
);

    localparam int OW = IW + 2;

    logic signed [OW-1:0] a_re_s [FFT_N];
    logic signed [OW-1:0] a_im_s [FFT_N];

    // Sign-extend operands to the output width before summing
    always_comb begin
        for (int i = 0; i < FFT_N; i++) begin
            a_re_s[i] = OW'(x_re[i]);
            a_im_s[i] = OW'(x_im[i]);
        end
    end

    // Inverse kernel: multiplying by j maps (a + jb) to (-b + ja)
    always_comb begin
        y_re[0] = a_re_s[0] + a_re_s[1] + a_re_s[2] + a_re_s[3];
        y_im[0] = a_im_s[0] + a_im_s[1] + a_im_s[2] + a_im_s[3];
        y_re[1] = a_re_s[0] - a_im_s[1] - a_re_s[2] + a_im_s[3];
        y_im[1] = a_im_s[0] + a_re_s[1] - a_im_s[2] - a_re_s[3];
        y_re[2] = a_re_s[0] - a_re_s[1] + a_re_s[2] - a_re_s[3];
        y_im[2] = a_im_s[0] - a_im_s[1] + a_im_s[2] - a_im_s[3];
        y_re[3] = a_re_s[0] + a_im_s[1] - a_re_s[2] - a_im_s[3];
        y_im[3] = a_im_s[0] - a_re_s[1] - a_im_s[2] + a_re_s[3];
    end

endmodule

// File: rtl/ifft_4x4_2d.sv
// Inverse 4x4 2D transform: row pass, column pass through one shared butterfly,
// 1/16 scaling, and one real output row per cycle.
module ifft_4x4_2d
    import fft_pkg::*;
#(
    parameter int W = FFT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] din_real_0,  din_real_1,  din_real_2,  din_real_3,
    input  logic signed [W-1:0] din_real_4,  din_real_5,  din_real_6,  din_real_7,
    input  logic signed [W-1:0] din_real_8,  din_real_9,  din_real_10, din_real_11,
    input  logic signed [W-1:0] din_real_12, din_real_13, din_real_14, din_real_15,
    input  logic signed [W-1:0] din_imag_0,  din_imag_1,  din_imag_2,  din_imag_3,
    input  logic signed [W-1:0] din_imag_4,  din_imag_5,  din_imag_6,  din_imag_7,
    input  logic signed [W-1:0] din_imag_8,  din_imag_9,  din_imag_10, din_imag_11,
    input  logic signed [W-1:0] din_imag_12, din_imag_13, din_imag_14, din_imag_15,
    output logic signed [W-1:0] dout_real_0,
    output logic signed [W-1:0] dout_real_1,
    output logic signed [W-1:0] dout_real_2,
    output logic signed [W-1:0] dout_real_3,
    output logic [1:0]          dout_row,
    output logic                dout_valid,
    output logic                busy,
    output logic                done
);

    localparam int BW = W + 2 * FFT_GROW;

    fft_state_e          state_r, next_state_s;
    logic [1:0]          idx_r, next_idx_s, row_n_s;
    logic signed [W-1:0] din_re_s [16];
    logic signed [W-1:0] din_im_s [16];
    logic signed [BW-1:0] buf_re_r [16];
    logic signed [BW-1:0] buf_im_r [16];
    logic [3:0]          addr_s [FFT_N];
    logic signed [BW-1:0] bf_in_re_s [FFT_N];
    logic signed [BW-1:0] bf_in_im_s [FFT_N];
    logic signed [BW+1:0] bf_out_re_s [FFT_N];
    logic signed [BW+1:0] bf_out_im_s [FFT_N];
    logic signed [BW-1:0] src_s [FFT_N];
    logic signed [W-1:0] dout_nxt_s [FFT_N];
    logic signed [W-1:0] dout_r [FFT_N];
    logic [1:0]          dout_row_r;
    logic                dout_valid_r, busy_r, done_r;
    logic                unused_bits_s;

    assign din_re_s = '{din_real_0, din_real_1, din_real_2, din_real_3,
                        din_real_4, din_real_5, din_real_6, din_real_7,
                        din_real_8, din_real_9, din_real_10, din_real_11,
                        din_real_12, din_real_13, din_real_14, din_real_15};
    assign din_im_s = '{din_imag_0, din_imag_1, din_imag_2, din_imag_3,
                        din_imag_4, din_imag_5, din_imag_6, din_imag_7,
                        din_imag_8, din_imag_9, din_imag_10, din_imag_11,
                        din_imag_12, din_imag_13, din_imag_14, din_imag_15};

    // State and phase index register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
        end else begin
            state_r <= next_state_s;
            idx_r   <= next_idx_s;
        end
    end

    // Next-state logic: each working phase lasts four cycles of idx
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                next_idx_s = 2'd0;
                if (start) begin
                    next_state_s = ST_ROW;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ROW: begin
                next_idx_s = idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    next_state_s = ST_COL;
                end else begin
                    next_state_s = ST_ROW;
                end
            end
            ST_COL: begin
                next_idx_s = idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    next_state_s = ST_OUT;
                end else begin
                    next_state_s = ST_COL;
                end
            end
            ST_OUT: begin
                next_idx_s = idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_OUT;
                end
            end
            ST_DONE: begin
                next_idx_s   = 2'd0;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_idx_s   = 2'd0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand selection: row idx in ROW, column idx in COL
    always_comb begin
        for (int c = 0; c < FFT_N; c++) begin
            if (state_r == ST_COL) begin
                addr_s[c] = {2'(c), idx_r};
            end else begin
                addr_s[c] = {idx_r, 2'(c)};
            end
            bf_in_re_s[c] = buf_re_r[addr_s[c]];
            bf_in_im_s[c] = buf_im_r[addr_s[c]];
        end
    end

    ifft4_butterfly #(.IW(BW)) u_bfly (
        .x_re (bf_in_re_s),
        .x_im (bf_in_im_s),
        .y_re (bf_out_re_s),
        .y_im (bf_out_im_s)
    );

    // The buffer is sized so the two growth bits above BW are always redundant sign bits
    assign unused_bits_s = ^{bf_out_re_s[0][BW+1:BW], bf_out_re_s[1][BW+1:BW],
                             bf_out_re_s[2][BW+1:BW], bf_out_re_s[3][BW+1:BW],
                             bf_out_im_s[0][BW+1:BW], bf_out_im_s[1][BW+1:BW],
                             bf_out_im_s[2][BW+1:BW], bf_out_im_s[3][BW+1:BW]};

    // Complex buffer: load on start, in-place write-back during ROW and COL
    always_ff @(posedge clk) begin
        if (state_r == ST_IDLE && start) begin
            for (int k = 0; k < 16; k++) begin
                buf_re_r[k] <= BW'(din_re_s[k]);
                buf_im_r[k] <= BW'(din_im_s[k]);
            end
        end else if (state_r == ST_ROW || state_r == ST_COL) begin
            for (int c = 0; c < FFT_N; c++) begin
                buf_re_r[addr_s[c]] <= bf_out_re_s[c][BW-1:0];
                buf_im_r[addr_s[c]] <= bf_out_im_s[c][BW-1:0];
            end
        end else begin
            buf_re_r <= buf_re_r;
            buf_im_r <= buf_im_r;
        end
    end

    // Next output row; row 0 column 3 is forwarded from the butterfly while it is still being written
    always_comb begin
        if (state_r == ST_COL) begin
            row_n_s = 2'd0;
        end else begin
            row_n_s = idx_r + 2'd1;
        end
        for (int c = 0; c < FFT_N; c++) begin
            if (state_r == ST_COL && c == 3) begin
                src_s[c] = bf_out_re_s[0][BW-1:0];
            end else begin
                src_s[c] = buf_re_r[{row_n_s, 2'(c)}];
            end
            dout_nxt_s[c] = src_s[c][BW-1 -: W];
        end
    end

    // Registered outputs, zero whenever no row is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < FFT_N; c++) begin
                dout_r[c] <= '0;
            end
            dout_row_r   <= 2'd0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (next_state_s == ST_OUT) begin
                dout_r       <= dout_nxt_s;
                dout_row_r   <= row_n_s;
                dout_valid_r <= 1'b1;
            end else begin
                for (int c = 0; c < FFT_N; c++) begin
                    dout_r[c] <= '0;
                end
                dout_row_r   <= 2'd0;
                dout_valid_r <= 1'b0;
            end
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    assign dout_real_0 = dout_r[0];
    assign dout_real_1 = dout_r[1];
    assign dout_real_2 = dout_r[2];
    assign dout_real_3 = dout_r[3];
    assign dout_row    = dout_row_r;
    assign dout_valid  = dout_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_ifft_4x4_2d.sv
// Self-checking bench for ifft_4x4_2d against a direct 2D inverse DFT model.
module tb_ifft_4x4_2d;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] din_re [16];
    logic signed [15:0] din_im [16];
    logic signed [15:0] dout [4];
    logic [1:0]         dout_row;
    logic               dout_valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int xr [16];
    int xi [16];
    int expv [16];

    always #5 clk = ~clk;

    ifft_4x4_2d dut (
        .clk(clk), .reset(reset), .start(start),
        .din_real_0(din_re[0]),   .din_real_1(din_re[1]),   .din_real_2(din_re[2]),   .din_real_3(din_re[3]),
        .din_real_4(din_re[4]),   .din_real_5(din_re[5]),   .din_real_6(din_re[6]),   .din_real_7(din_re[7]),
        .din_real_8(din_re[8]),   .din_real_9(din_re[9]),   .din_real_10(din_re[10]), .din_real_11(din_re[11]),
        .din_real_12(din_re[12]), .din_real_13(din_re[13]), .din_real_14(din_re[14]), .din_real_15(din_re[15]),
        .din_imag_0(din_im[0]),   .din_imag_1(din_im[1]),   .din_imag_2(din_im[2]),   .din_imag_3(din_im[3]),
        .din_imag_4(din_im[4]),   .din_imag_5(din_im[5]),   .din_imag_6(din_im[6]),   .din_imag_7(din_im[7]),
        .din_imag_8(din_im[8]),   .din_imag_9(din_im[9]),   .din_imag_10(din_im[10]), .din_imag_11(din_im[11]),
        .din_imag_12(din_im[12]), .din_imag_13(din_im[13]), .din_imag_14(din_im[14]), .din_imag_15(din_im[15]),
        .dout_real_0(dout[0]), .dout_real_1(dout[1]), .dout_real_2(dout[2]), .dout_real_3(dout[3]),
        .dout_row(dout_row), .dout_valid(dout_valid), .busy(busy), .done(done)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // x[n1][n2] = floor(sum_k X[k] * j^(k1*n1 + k2*n2) / 16), real part, wrapped to 16 bits
    task automatic ref_ifft();
        for (int n = 0; n < 16; n++) begin
            int s;
            logic signed [15:0] t;
            s = 0;
            for (int k = 0; k < 16; k++) begin
                case (((k / 4) * (n / 4) + (k % 4) * (n % 4)) % 4)
                    0: s += xr[k];
                    1: s -= xi[k];
                    2: s -= xr[k];
                    default: s += xi[k];
                endcase
            end
            t = 16'(s >>> 4);
            expv[n] = int'(t);
        end
    endtask

    // Forward 4x4 DFT of a real image held in xr (kernel (-j)^m), result written back to xr/xi
    task automatic fwd_fft_real();
        int img [16];
        img = xr;
        for (int k = 0; k < 16; k++) begin
            int re, im;
            re = 0;
            im = 0;
            for (int n = 0; n < 16; n++) begin
                case (((k / 4) * (n / 4) + (k % 4) * (n % 4)) % 4)
                    0: re += img[n];
                    1: im -= img[n];
                    2: re -= img[n];
                    default: im += img[n];
                endcase
            end
            xr[k] = re;
            xi[k] = im;
        end
    endtask

    task automatic load_random();
        for (int k = 0; k < 16; k++) begin
            logic signed [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            xr[k] = int'(a);
            xi[k] = int'(b);
        end
    endtask

    // mode 0: plain run; 1: extra start pulses in cycles 3 and 13; 2: reset in cycle 6
    task automatic run_txn(input int mode, input string name);
        int  dones;
        logic eb, ev, ed;
        dones = 0;
        for (int k = 0; k < 16; k++) begin
            din_re[k] = 16'(xr[k]);
            din_im[k] = 16'(xi[k]);
        end
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                for (int k = 0; k < 16; k++) begin
                    din_re[k] = 16'($urandom);
                    din_im[k] = 16'($urandom);
                end
            end
            if (mode == 2) begin
                eb = (cyc <= 6);
                ev = 1'b0;
                ed = 1'b0;
            end else begin
                eb = (cyc <= 13);
                ev = (cyc >= 9 && cyc <= 12);
                ed = (cyc == 13);
            end
            if (done === 1'b1) dones++;
            check_eq($sformatf("%s busy c%0d", name, cyc), 32'(busy), 32'(eb));
            check_eq($sformatf("%s valid c%0d", name, cyc), 32'(dout_valid), 32'(ev));
            check_eq($sformatf("%s done c%0d", name, cyc), 32'(done), 32'(ed));
            check_eq($sformatf("%s row c%0d", name, cyc), 32'(dout_row), ev ? 32'(cyc - 9) : 32'd0);
            for (int c = 0; c < 4; c++) begin
                check_eq($sformatf("%s x[%0d][%0d]", name, ev ? cyc - 9 : 0, c), 32'(dout[c]),
                         ev ? 32'(expv[4 * (cyc - 9) + c]) : 32'd0);
            end
            start = (mode == 1) && (cyc == 3 || cyc == 13);
            reset = (mode == 2) && (cyc == 6);
        end
        check_eq({name, " done count"}, 32'(dones), (mode == 2) ? 32'd0 : 32'd1);
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            din_re[k] = 16'sd100;
            din_im[k] = 16'sd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset valid", 32'(dout_valid), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset row", 32'(dout_row), 32'd0);
        for (int c = 0; c < 4; c++) check_eq("reset dout", 32'(dout[c]), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        xr = '{default: 0}; xi = '{default: 0}; expv = '{default: 0};
        run_txn(0, "zero");

        xr[0] = 16;  expv = '{default: 1};  run_txn(0, "dc+16");
        xr[0] = -16; expv = '{default: -1}; run_txn(0, "dc-16");
        xr[0] = 8;   expv = '{default: 0};  run_txn(0, "dc+8");
        xr[0] = -8;  expv = '{default: -1}; run_txn(0, "dc-8");

        xr = '{default: 16}; expv = '{default: 0}; expv[0] = 16;
        run_txn(0, "all16");

        for (int n = 0; n < 16; n++) begin
            xr[n]   = n + 1;
            expv[n] = n + 1;
        end
        fwd_fft_real();
        run_txn(0, "roundtrip");

        for (int t = 0; t < 6; t++) begin
            load_random();
            ref_ifft();
            run_txn(0, $sformatf("rand%0d", t));
        end

        load_random(); ref_ifft(); run_txn(1, "restart");
        load_random(); ref_ifft(); run_txn(2, "midreset");
        load_random(); ref_ifft(); run_txn(0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
